// File: rtl/calc_pkg.sv
// Shared types for the RPN calculator: token kinds, opcodes, FSM states and
// token field positions, plus the operand sign-extension helper.
package calc_pkg;

  typedef enum logic [1:0] {
    K_PUSH  = 2'd0,
    K_OP    = 2'd1,
    K_EQUAL = 2'd2,
    K_CLEAR = 2'd3
  } kind_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_NEG  = 3'd3,
    OP_DUP  = 3'd4,
    OP_DROP = 3'd5,
    OP_SWAP = 3'd6,
    OP_NOP  = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  localparam int TOK_W     = 16;
  localparam int KIND_MSB  = 15;
  localparam int KIND_LSB  = 14;
  localparam int OPND_MSB  = 13;
  localparam int OPC_MSB   = 2;
  localparam int MAX_WIDTH = 64;

  // Callers truncate the result to their datapath width (WIDTH <= MAX_WIDTH).
  function automatic logic [MAX_WIDTH-1:0] sext_operand(input logic [OPND_MSB:0] opnd);
    return {{(MAX_WIDTH-OPND_MSB-1){opnd[OPND_MSB]}}, opnd};
  endfunction

endpackage

// File: rtl/calc_stack.sv
// Register-array operand stack: pop (0..2) then push in one cycle, plus swap of the top two.
// Single-cycle update; no backpressure, the caller guarantees legal requests.
module calc_stack
  import calc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int DW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [1:0]       pop_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             swap,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             has2
);

  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    depth_r;
  logic [DW-1:0]    base;
  logic [IW-1:0]    top_i;
  logic [IW-1:0]    next_i;
  logic [IW-1:0]    wr_i;

  assign base   = depth_r - DW'(pop_n);
  assign top_i  = IW'(depth_r - DW'(1));
  assign next_i = IW'(depth_r - DW'(2));
  assign wr_i   = IW'(base);

  assign depth = depth_r;
  assign empty = (depth_r == '0);
  assign full  = (depth_r == DW'(DEPTH));
  assign has2  = (depth_r >= DW'(2));
  assign top   = empty ? '0 : mem[top_i];
  assign next  = has2 ? mem[next_i] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth_r <= '0;
    end else if (clear) begin
      depth_r <= '0;
    end else begin
      depth_r <= base + DW'(push);
    end
  end

  // Entry storage is datapath only; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (swap) begin
        mem[top_i]  <= next;
        mem[next_i] <= top;
      end
      if (push) begin
        mem[wr_i] <= push_data;
      end
    end
  end

endmodule

// File: rtl/calc_rpn_engine.sv
// RPN token engine: pops tokens from a FWFT FIFO, executes them on the operand stack, and
// presents the top on EQUAL. At most 1 token per 2 cycles; a stalled result stalls the FIFO.
module calc_rpn_engine
  import calc_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [WIDTH-1:0]                 fifo_data_i,
  input  logic                             fifo_empty_i,
  output logic                             fifo_rd_o,
  output logic [WIDTH-1:0]                 res_data_o,
  output logic                             res_valid_o,
  input  logic                             res_ready_i,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth_o,
  output logic                             err_underflow_o,
  output logic                             err_overflow_o,
  output logic                             busy_o
);

  localparam int DW = $clog2(STACK_DEPTH+1);

  state_e           state;
  logic [TOK_W-1:0] tok;
  kind_e            kind;
  opcode_e          opc;

  logic [WIDTH-1:0] top, next, push_data;
  logic [1:0]       pop_n;
  logic             push, swap, clear, full, empty, has2;
  logic             unf, ovf, to_out;

  assign kind      = kind_e'(tok[KIND_MSB:KIND_LSB]);
  assign opc       = opcode_e'(tok[OPC_MSB:0]);
  assign fifo_rd_o = (state == S_FETCH) && !fifo_empty_i;
  assign busy_o    = !((state == S_FETCH) && fifo_empty_i);

  calc_stack #(.WIDTH(WIDTH), .DEPTH(STACK_DEPTH), .DW(DW)) u_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .pop_n     (pop_n),
    .push      (push),
    .push_data (push_data),
    .swap      (swap),
    .top       (top),
    .next      (next),
    .depth     (depth_o),
    .full      (full),
    .empty     (empty),
    .has2      (has2)
  );

  // Stack requests and error pulses are only asserted in S_EXEC.
  always_comb begin
    pop_n     = 2'd0;
    push      = 1'b0;
    swap      = 1'b0;
    clear     = 1'b0;
    push_data = top;
    unf       = 1'b0;
    ovf       = 1'b0;
    to_out    = 1'b0;
    if (state == S_EXEC) begin
      case (kind)
        K_PUSH: begin
          if (full) ovf = 1'b1;
          else begin
            push      = 1'b1;
            push_data = WIDTH'(sext_operand(tok[OPND_MSB:0]));
          end
        end
        K_OP: begin
          case (opc)
            OP_ADD, OP_SUB, OP_MUL: begin
              if (!has2) unf = 1'b1;
              else begin
                pop_n = 2'd2;
                push  = 1'b1;
                if (opc == OP_ADD)      push_data = next + top;
                else if (opc == OP_SUB) push_data = next - top;
                else                    push_data = next * top;
              end
            end
            OP_NEG: begin
              if (empty) unf = 1'b1;
              else begin
                pop_n     = 2'd1;
                push      = 1'b1;
                push_data = WIDTH'(0) - top;
              end
            end
            OP_DUP: begin
              if (empty)     unf  = 1'b1;
              else if (full) ovf  = 1'b1;
              else           push = 1'b1;
            end
            OP_DROP: begin
              if (empty) unf = 1'b1;
              else       pop_n = 2'd1;
            end
            OP_SWAP: begin
              if (!has2) unf  = 1'b1;
              else       swap = 1'b1;
            end
            default: ;
          endcase
        end
        K_EQUAL: begin
          if (empty) unf    = 1'b1;
          else       to_out = 1'b1;
        end
        K_CLEAR: clear = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      tok             <= '0;
      res_data_o      <= '0;
      res_valid_o     <= 1'b0;
      err_underflow_o <= 1'b0;
      err_overflow_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (!fifo_empty_i) begin
            tok   <= fifo_data_i[TOK_W-1:0];
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (to_out) begin
            res_data_o  <= top;
            res_valid_o <= 1'b1;
            state       <= S_OUT;
          end else begin
            state <= S_FETCH;
          end
        end
        S_OUT: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            state       <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (clear) begin
        err_underflow_o <= 1'b0;
        err_overflow_o  <= 1'b0;
      end else begin
        if (unf) err_underflow_o <= 1'b1;
        if (ovf) err_overflow_o  <= 1'b1;
      end
    end
  end

endmodule
